// File: rtl/simon_sequencer.sv
// Simon memory game sequencer: grows a random button sequence, plays it back,
// then checks the player's echo of it, with timeout, loss and win states.
module simon_sequencer #(
  parameter int MAX_LEN       = 16,
  parameter int HOLD_TICKS    = 30,
  parameter int GAP_TICKS     = 15,
  parameter int TIMEOUT_TICKS = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] playerNum,
  input  logic       playerPressed,
  output logic       simonTurn,
  output logic [1:0] simonNum,
  output logic       simonPressed,
  output logic [4:0] level,
  output logic       gameOver,
  output logic       win
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int MAX_HG = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int MAX_T  = (MAX_HG > TIMEOUT_TICKS) ? MAX_HG : TIMEOUT_TICKS;
  localparam int CNT_W  = $clog2(MAX_T + 1);

  typedef enum logic [3:0] {
    IDLE, ADD, PLAY_ON, PLAY_OFF, WAIT_PRESS, WAIT_RELEASE, CHECK, OVER, WIN
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cap_q, cap_d;
  logic             turn_q, turn_d;
  logic             prev_q;
  logic [1:0]       seq_q [MAX_LEN];
  logic             seq_we;
  logic             press_rise;
  logic             last_idx;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign press_rise = playerPressed & ~prev_q;
  assign last_idx   = (LEN_W'(idx_q) == len_q - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_step(lfsr_q);
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    turn_d  = turn_q;
    seq_we  = 1'b0;
    case (state_q)
      IDLE, OVER, WIN: begin
        if (start) begin
          len_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        seq_we  = 1'b1;
        len_d   = len_q + LEN_W'(1);
        idx_d   = '0;
        cnt_d   = '0;
        turn_d  = 1'b1;
        state_d = PLAY_ON;
      end
      PLAY_ON: begin
        if (cnt_q == CNT_W'(HOLD_TICKS - 1)) begin
          cnt_d   = '0;
          state_d = PLAY_OFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PLAY_OFF: begin
        if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
          cnt_d = '0;
          if (last_idx) begin
            idx_d   = '0;
            turn_d  = 1'b0;
            state_d = WAIT_PRESS;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = PLAY_ON;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_PRESS: begin
        // Only a fresh edge counts, so a button held over from playback is ignored.
        if (press_rise) begin
          cap_d   = playerNum;
          state_d = WAIT_RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
          state_d = OVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (playerPressed) cap_d = playerNum;
        else               state_d = CHECK;
      end
      CHECK: begin
        if (cap_q != seq_q[idx_q]) begin
          state_d = OVER;
        end else if (!last_idx) begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          state_d = WAIT_PRESS;
        end else if (len_q == LEN_W'(MAX_LEN)) begin
          state_d = WIN;
        end else begin
          state_d = ADD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= 16'hACE1;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      turn_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      prev_q  <= playerPressed;
    end
  end

  // Sequence memory and the captured player button carry data only, no reset.
  always_ff @(posedge clk) begin
    cap_q <= cap_d;
    if (seq_we) seq_q[len_q[IDX_W-1:0]] <= lfsr_q[1:0];
  end

  assign simonTurn    = turn_q;
  assign simonPressed = (state_q == PLAY_ON);
  assign simonNum     = turn_q ? seq_q[idx_q] : 2'b00;
  assign level        = 5'(len_q);
  assign gameOver     = (state_q == OVER);
  assign win          = (state_q == WIN);

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer: playback timing, echo checking, loss,
// timeout, win (MAX_LEN=2 instance sharing the same inputs) and reset.
module tb_simon_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] playerNum;
  logic       playerPressed;

  logic       s_turn, s_pressed, game_over, win_o;
  logic [1:0] s_num;
  logic [4:0] level;

  logic       w_turn, w_pressed, w_game_over, w_win;
  logic [1:0] w_num;
  logic [4:0] w_level;

  int total;
  int bad;

  logic [15:0] m_lfsr;
  logic [1:0]  exp_seq [16];

  simon_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start),
    .playerNum(playerNum), .playerPressed(playerPressed),
    .simonTurn(s_turn), .simonNum(s_num), .simonPressed(s_pressed),
    .level(level), .gameOver(game_over), .win(win_o)
  );

  simon_sequencer #(.MAX_LEN(2)) u_win (
    .clk(clk), .reset(reset), .start(start),
    .playerNum(playerNum), .playerPressed(playerPressed),
    .simonTurn(w_turn), .simonNum(w_num), .simonPressed(w_pressed),
    .level(w_level), .gameOver(w_game_over), .win(w_win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    exp_seq[0] = m_lfsr[1:0];
    total++;
    if ({level, s_turn, game_over, win_o} !== 8'b0) begin
      bad++;
      $display("FAIL add_cycle: level=%0d turn=%b over=%b win=%b want all 0", level, s_turn, game_over, win_o);
    end
    start = 1'b0;
    tick();
    total++;
    if (s_turn !== 1'b1 || level !== 5'd1 || s_pressed !== 1'b1) begin
      bad++;
      $display("FAIL first_play: turn=%b level=%0d pressed=%b want 1/1/1", s_turn, level, s_pressed);
    end
  endtask

  task automatic check_playback(input int n);
    logic       ok;
    logic [3:0] got, want;
    for (int i = 0; i < n; i++) begin
      ok = 1'b1; got = '0; want = {2'b11, exp_seq[i]};
      for (int j = 0; j < 30; j++) begin
        if (ok && {s_turn, s_pressed, s_num} !== {2'b11, exp_seq[i]}) begin
          ok = 1'b0; got = {s_turn, s_pressed, s_num};
        end
        tick();
      end
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL playback_on[%0d]: turn,pressed,num=%b want %b", i, got, want);
      end
      ok = 1'b1; want = {2'b10, exp_seq[i]};
      for (int j = 0; j < 15; j++) begin
        if (ok && {s_turn, s_pressed, s_num} !== {2'b10, exp_seq[i]}) begin
          ok = 1'b0; got = {s_turn, s_pressed, s_num};
        end
        tick();
      end
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL playback_off[%0d]: turn,pressed,num=%b want %b", i, got, want);
      end
    end
    total++;
    if (s_turn !== 1'b0 || s_pressed !== 1'b0) begin
      bad++;
      $display("FAIL handover: turn=%b pressed=%b want 0/0", s_turn, s_pressed);
    end
  endtask

  // Echo the first n stored buttons; returns in the first PLAY_ON cycle of the next round.
  task automatic play_round(input int n);
    for (int i = 0; i < n; i++) begin
      playerPressed = 1'b1;
      playerNum     = exp_seq[i];
      repeat (5) tick();
      playerPressed = 1'b0;
      tick();
      total++;
      if (game_over !== 1'b0) begin
        bad++;
        $display("FAIL echo_check[%0d]: gameOver=%b want 0", i, game_over);
      end
      if (i < n - 1) tick();
    end
    tick();
    exp_seq[n] = m_lfsr[1:0];
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; playerPressed = 1'b0; playerNum = 2'd0;
    tick();
    tick();
    total++;
    if ({s_turn, s_num, s_pressed, level, game_over, win_o} !== 11'b0) begin
      bad++;
      $display("FAIL reset_outputs: turn=%b num=%0d pressed=%b level=%0d over=%b win=%b want all 0",
               s_turn, s_num, s_pressed, level, game_over, win_o);
    end
    reset = 1'b0;
    tick();
    total++;
    if (level !== 5'd0 || s_turn !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: level=%0d turn=%b want 0/0", level, s_turn);
    end
  endtask

  task automatic test_first_round();
    start_game();
    check_playback(1);
  endtask

  task automatic test_correct_echo();
    play_round(1);
    total++;
    if (level !== 5'd2 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL level2: level=%0d over=%b want 2/0", level, game_over);
    end
    check_playback(2);
    play_round(2);
    total++;
    if (level !== 5'd3) begin
      bad++;
      $display("FAIL level3: level=%0d want 3", level);
    end
    check_playback(3);
  endtask

  task automatic test_wrong_press();
    playerPressed = 1'b1;
    playerNum     = exp_seq[0] ^ 2'b01;
    repeat (5) tick();
    playerPressed = 1'b0;
    tick();
    total++;
    if (game_over !== 1'b0) begin
      bad++;
      $display("FAIL wrong_check_cycle: gameOver=%b want 0", game_over);
    end
    tick();
    total++;
    if (game_over !== 1'b1 || level !== 5'd3) begin
      bad++;
      $display("FAIL wrong_over: gameOver=%b level=%0d want 1/3", game_over, level);
    end
    playerPressed = 1'b1;
    repeat (3) tick();
    playerPressed = 1'b0;
    repeat (10) tick();
    total++;
    if (game_over !== 1'b1 || level !== 5'd3) begin
      bad++;
      $display("FAIL over_sticky: gameOver=%b level=%0d want 1/3", game_over, level);
    end
    start_game();
  endtask

  task automatic test_timeout();
    playerPressed = 1'b1;
    playerNum     = exp_seq[0];
    check_playback(1);
    for (int c = 0; c < 299; c++) begin
      start = (c == 100);
      tick();
    end
    start = 1'b0;
    total++;
    if (game_over !== 1'b0 || level !== 5'd1) begin
      bad++;
      $display("FAIL timeout_early: gameOver=%b level=%0d want 0/1", game_over, level);
    end
    tick();
    total++;
    if (game_over !== 1'b1) begin
      bad++;
      $display("FAIL timeout_over: gameOver=%b want 1", game_over);
    end
    playerPressed = 1'b0;
    tick();
  endtask

  task automatic test_win();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start_game();
    check_playback(1);
    play_round(1);
    total++;
    if (w_level !== 5'd2 || w_win !== 1'b0) begin
      bad++;
      $display("FAIL win_round2: level=%0d win=%b want 2/0", w_level, w_win);
    end
    check_playback(2);
    play_round(2);
    total++;
    if (w_win !== 1'b1 || w_level !== 5'd2 || w_game_over !== 1'b0 || w_turn !== 1'b0) begin
      bad++;
      $display("FAIL win_state: win=%b level=%0d over=%b turn=%b want 1/2/0/0", w_win, w_level, w_game_over, w_turn);
    end
    total++;
    if (level !== 5'd3 || win_o !== 1'b0) begin
      bad++;
      $display("FAIL no_win_long: level=%0d win=%b want 3/0", level, win_o);
    end
  endtask

  task automatic test_reset_mid();
    repeat (7) tick();
    total++;
    if (s_pressed !== 1'b1) begin
      bad++;
      $display("FAIL mid_play: pressed=%b want 1", s_pressed);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({s_turn, s_num, s_pressed, level, game_over, win_o, w_win, w_level} !== 17'b0) begin
      bad++;
      $display("FAIL reset_mid: turn=%b num=%0d pressed=%b level=%0d over=%b win=%b wwin=%b wlevel=%0d want all 0",
               s_turn, s_num, s_pressed, level, game_over, win_o, w_win, w_level);
    end
    reset = 1'b0;
    tick();
    total++;
    if (level !== 5'd0 || s_turn !== 1'b0 || s_pressed !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: level=%0d turn=%b pressed=%b want 0/0/0", level, s_turn, s_pressed);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_first_round();
    test_correct_echo();
    test_wrong_press();
    test_timeout();
    test_win();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
